// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch resolution controller:
// B-type funct3 codes and the controller state encoding.
package branch_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/branch_ctrl_cond.sv
// Combinational branch condition: compares the operands and decodes funct3
// into a taken condition plus an illegal-encoding flag.
module branch_cond_unit
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond,
    output logic            illegal
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1 == rs2);
    assign lt  = ($signed(rs1) < $signed(rs2));
    assign ltu = (rs1 < rs2);

    // funct3 decode; 010/011 are not branch encodings and never take
    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = !lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = !ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: accepts one decoded branch, evaluates it the
// following cycle, then drives redirect/flush and keeps taken statistics.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_funct3,
    input  logic [XLEN-1:0]  br_rs1,
    input  logic [XLEN-1:0]  br_rs2,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    output logic             res_valid,
    output logic             res_taken,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             err_funct3,
    output logic             err_misalign,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_ntaken,
    input  logic             cnt_clr
);

    // Counter reloads with FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t            state, state_d;
    logic [3:0]        fcnt, fcnt_d;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_rs1, req_rs2, req_pc, req_imm;
    logic [XLEN-1:0]   target;
    logic              cond, illegal;
    logic              accept;
    logic              res_valid_d, res_taken_d, redirect_d;
    logic              err_funct3_d, err_misalign_d;
    logic [XLEN-1:0]   redirect_pc_d;

    branch_cond_unit #(.XLEN(XLEN)) u_cond (
        .funct3  (req_funct3),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .cond    (cond),
        .illegal (illegal)
    );

    // Target wraps modulo 2^XLEN by construction
    assign target   = req_pc + req_imm;
    assign br_ready = (state == ST_IDLE);
    assign flush    = (state == ST_FLUSH);

    // State, flush counter and registered result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            fcnt         <= '0;
            res_valid    <= 1'b0;
            res_taken    <= 1'b0;
            redirect     <= 1'b0;
            err_funct3   <= 1'b0;
            err_misalign <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            state        <= state_d;
            fcnt         <= fcnt_d;
            res_valid    <= res_valid_d;
            res_taken    <= res_taken_d;
            redirect     <= redirect_d;
            err_funct3   <= err_funct3_d;
            err_misalign <= err_misalign_d;
            redirect_pc  <= redirect_pc_d;
        end
    end

    // Next-state and next-output logic; pulses default low every cycle
    always_comb begin
        state_d        = state;
        fcnt_d         = fcnt;
        accept         = 1'b0;
        res_valid_d    = 1'b0;
        res_taken_d    = 1'b0;
        redirect_d     = 1'b0;
        err_funct3_d   = 1'b0;
        err_misalign_d = 1'b0;
        redirect_pc_d  = redirect_pc;
        case (state)
            ST_IDLE: begin
                if (br_valid) begin
                    accept  = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                res_valid_d = 1'b1;
                state_d     = ST_IDLE;
                if (illegal) begin
                    err_funct3_d = 1'b1;
                end else if (cond) begin
                    res_taken_d = 1'b1;
                    if (target[1:0] != 2'b00) begin
                        // Misaligned target: report, but never redirect or flush
                        err_misalign_d = 1'b1;
                    end else begin
                        redirect_d    = 1'b1;
                        redirect_pc_d = target;
                        fcnt_d        = FLUSH_LOAD;
                        state_d       = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (fcnt == 4'd0) state_d = ST_IDLE;
                else              fcnt_d  = fcnt - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture, only on a valid/ready transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_funct3 <= '0;
            req_rs1    <= '0;
            req_rs2    <= '0;
            req_pc     <= '0;
            req_imm    <= '0;
        end else if (accept) begin
            req_funct3 <= br_funct3;
            req_rs1    <= br_rs1;
            req_rs2    <= br_rs2;
            req_pc     <= br_pc;
            req_imm    <= br_imm;
        end
    end

    // Saturating statistics, counted on the result pulse; clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_taken  <= '0;
            cnt_ntaken <= '0;
        end else if (cnt_clr) begin
            cnt_taken  <= '0;
            cnt_ntaken <= '0;
        end else if (res_valid) begin
            if (res_taken) begin
                if (cnt_taken != '1) cnt_taken <= cnt_taken + 1'b1;
            end else begin
                if (cnt_ntaken != '1) cnt_ntaken <= cnt_ntaken + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a vector table for single branches plus
// hand sequences for back-to-back requests, counter clear and mid-flush reset.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [2:0]  br_funct3 = '0;
    logic [31:0] br_rs1 = '0, br_rs2 = '0, br_pc = '0, br_imm = '0;
    logic        res_valid, res_taken, redirect, flush, err_funct3, err_misalign;
    logic [31:0] redirect_pc;
    logic [15:0] cnt_taken, cnt_ntaken;
    logic        cnt_clr = 1'b0;

    int tests = 0;
    int fails = 0;
    int m_taken = 0;
    int m_ntaken = 0;
    logic [31:0] last_pc = '0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1, rs2, pc, imm;
        logic        taken, redir, ef3, emis;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[10];

    branch_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .br_funct3(br_funct3), .br_rs1(br_rs1), .br_rs2(br_rs2), .br_pc(br_pc),
        .br_imm(br_imm), .res_valid(res_valid), .res_taken(res_taken),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .err_funct3(err_funct3), .err_misalign(err_misalign),
        .cnt_taken(cnt_taken), .cnt_ntaken(cnt_ntaken), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (br_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (br_ready !== 1'b1) chk({name, "_ready_timeout"}, 32'(br_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        wait_ready(tag);
        br_funct3 = v.f3; br_rs1 = v.rs1; br_rs2 = v.rs2; br_pc = v.pc; br_imm = v.imm;
        br_valid = 1'b1;
        @(posedge clk); #1;
        br_valid = 1'b0;
        chk({tag, "_eval_ready"}, 32'(br_ready), 32'd0);
        chk({tag, "_eval_resv"}, 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, "_res_taken"}, 32'(res_taken), 32'(v.taken));
        chk({tag, "_redirect"}, 32'(redirect), 32'(v.redir));
        chk({tag, "_err_f3"}, 32'(err_funct3), 32'(v.ef3));
        chk({tag, "_err_mis"}, 32'(err_misalign), 32'(v.emis));
        chk({tag, "_flush"}, 32'(flush), 32'(v.redir));
        if (v.redir) last_pc = v.tgt;
        chk({tag, "_redirect_pc"}, redirect_pc, last_pc);
        if (v.taken) m_taken++; else m_ntaken++;
        if (v.redir) begin
            @(posedge clk); #1;
            chk({tag, "_flush2"}, 32'(flush), 32'd1);
            chk({tag, "_redir_pulse"}, 32'(redirect), 32'd0);
            chk({tag, "_busy"}, 32'(br_ready), 32'd0);
            @(posedge clk); #1;
            chk({tag, "_flush_end"}, 32'(flush), 32'd0);
            chk({tag, "_ready_back"}, 32'(br_ready), 32'd1);
        end else begin
            chk({tag, "_ready_nt"}, 32'(br_ready), 32'd1);
        end
    endtask

    initial begin
        //          f3      rs1           rs2           pc            imm           tk  rd  ef  em  tgt
        vecs[0] = '{3'b000, 32'h5,        32'h5,        32'h100,      32'h20,       1, 1, 0, 0, 32'h120};
        vecs[1] = '{3'b100, 32'hFFFF_FFFF, 32'h1,       32'h200,      32'h40,       1, 1, 0, 0, 32'h240};
        vecs[2] = '{3'b110, 32'hFFFF_FFFF, 32'h1,       32'h200,      32'h40,       0, 0, 0, 0, 32'h0};
        vecs[3] = '{3'b010, 32'h5,        32'h5,        32'h100,      32'h20,       0, 0, 1, 0, 32'h0};
        vecs[4] = '{3'b001, 32'h1,        32'h2,        32'h100,      32'h2,        1, 0, 0, 1, 32'h0};
        vecs[5] = '{3'b001, 32'h1,        32'h2,        32'hFFFF_FFF0, 32'h20,      1, 1, 0, 0, 32'h10};
        vecs[6] = '{3'b101, 32'h3,        32'hFFFF_FFFF, 32'h300,     32'hFFFF_FFF0, 1, 1, 0, 0, 32'h2F0};
        vecs[7] = '{3'b111, 32'h3,        32'hFFFF_FFFF, 32'h300,     32'h8,        0, 0, 0, 0, 32'h0};
        vecs[8] = '{3'b000, 32'h1,        32'h2,        32'h100,      32'h8,        0, 0, 0, 0, 32'h0};
        vecs[9] = '{3'b011, 32'h1,        32'h1,        32'h100,      32'h8,        0, 0, 1, 0, 32'h0};

        // Reset state
        #12;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_cnt_taken", 32'(cnt_taken), 32'd0);
        chk("rst_cnt_ntaken", 32'(cnt_ntaken), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(br_ready), 32'd1);

        // Vector table
        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));
        repeat (2) @(posedge clk); #1;
        chk("tbl_cnt_taken", 32'(cnt_taken), 32'(m_taken));
        chk("tbl_cnt_ntaken", 32'(cnt_ntaken), 32'(m_ntaken));

        // Clear, then back-to-back: valid held 10 cycles. Accepts land at
        // cycles 0 (taken), 4 (not taken), 6 (taken).
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("clr_taken", 32'(cnt_taken), 32'd0);
        chk("clr_ntaken", 32'(cnt_ntaken), 32'd0);
        begin
            int pulses = 0;
            int redirs = 0;
            for (int i = 0; i < 10; i++) begin
                br_funct3 = 3'b000;
                br_rs1 = 32'h7;
                br_rs2 = ((i % 2 == 0) && i != 4) ? 32'h7 : 32'h9;
                br_pc = 32'h400;
                br_imm = 32'h8;
                br_valid = 1'b1;
                @(posedge clk); #1;
                if (res_valid) pulses++;
                if (redirect) redirs++;
            end
            br_valid = 1'b0;
            chk("b2b_res_pulses", 32'(pulses), 32'd3);
            chk("b2b_redirects", 32'(redirs), 32'd2);
        end
        repeat (2) @(posedge clk); #1;
        chk("b2b_cnt_taken", 32'(cnt_taken), 32'd2);
        chk("b2b_cnt_ntaken", 32'(cnt_ntaken), 32'd1);

        // cnt_clr on the increment edge (the cycle res_valid is high)
        begin
            vec_t v;
            v = vecs[8];
            wait_ready("clr_inc");
            br_funct3 = v.f3; br_rs1 = v.rs1; br_rs2 = v.rs2; br_pc = v.pc; br_imm = v.imm;
            br_valid = 1'b1;
            @(posedge clk); #1;
            br_valid = 1'b0;
            @(posedge clk); #1;
            chk("clr_inc_resv", 32'(res_valid), 32'd1);
            cnt_clr = 1'b1;
            @(posedge clk); #1;
            cnt_clr = 1'b0;
            chk("clr_inc_taken", 32'(cnt_taken), 32'd0);
            chk("clr_inc_ntaken", 32'(cnt_ntaken), 32'd0);
        end

        // Reset asserted in the second flush cycle
        wait_ready("rstf");
        br_funct3 = 3'b000; br_rs1 = 32'h1; br_rs2 = 32'h1; br_pc = 32'h100; br_imm = 32'h20;
        br_valid = 1'b1;
        @(posedge clk); #1;
        br_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstf_redirect", 32'(redirect), 32'd1);
        @(posedge clk); #1;
        chk("rstf_flush_pre", 32'(flush), 32'd1);
        chk("rstf_cnt_pre", 32'(cnt_taken), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstf_flush_drop", 32'(flush), 32'd0);
        chk("rstf_cnt_taken", 32'(cnt_taken), 32'd0);
        chk("rstf_redirect_pc", redirect_pc, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstf_ready", 32'(br_ready), 32'd1);
        chk("rstf_flush_after", 32'(flush), 32'd0);
        chk("rstf_resv_after", 32'(res_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Sequences conditional-branch resolution for the RV32I core: accepts one decoded branch per handshake, evaluates the condition, computes the target and drives PC redirect and pipeline flush.
- Sits between decode and the PC/fetch stage. Replaces the single inequality flag with a full BEQ/BNE/BLT/BGE/BLTU/BGEU resolution path.
- Keeps taken/not-taken statistics counters.

Parameters:
- XLEN, 32, operand/PC width
- FLUSH_CYCLES, 2, cycles flush stays high after a taken redirect (1..15)
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- br_valid  in  1  branch request valid
- br_ready  out  1  block can accept a request
- br_funct3  in  3  B-type funct3
- br_rs1  in  XLEN  operand 1
- br_rs2  in  XLEN  operand 2
- br_pc  in  XLEN  PC of the branch
- br_imm  in  XLEN  sign-extended B-immediate
- res_valid  out  1  one-cycle pulse: resolution complete
- res_taken  out  1  branch taken (qualified by res_valid)
- redirect  out  1  one-cycle pulse: load PC with redirect_pc
- redirect_pc  out  XLEN  branch target
- flush  out  1  squash younger instructions in IF/ID
- err_funct3  out  1  one-cycle pulse: illegal funct3 (010/011)
- err_misalign  out  1  one-cycle pulse: taken target with target[1:0] != 0
- cnt_taken  out  CNT_W  count of taken branches
- cnt_ntaken  out  CNT_W  count of not-taken branches
- cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All pulses=0, flush=0, redirect_pc=0, counters=0.
  - br_ready=1 once rst_n deasserts.
- States and transitions:
  - IDLE: br_ready=1. On br_valid, register funct3, rs1, rs2, pc and imm, then go to EVAL.
  - EVAL (cycle after accept): br_ready=0.
    - Compare the registered operands:
      - BEQ 000: eq
      - BNE 001: !eq
      - BLT 100: signed lt
      - BGE 101: !signed lt
      - BLTU 110: unsigned lt
      - BGEU 111: !unsigned lt
    - Target = pc + imm, modulo 2^XLEN; wrap-around is silent.
    - Outputs at the end of EVAL (registered, visible the next cycle):
      - res_valid=1 and res_taken=condition.
      - Illegal funct3: err_funct3=1, res_taken=0, no redirect, go to IDLE.
      - Not taken: go to IDLE.
      - Taken with target[1:0] != 0: err_misalign=1, res_taken=1, no redirect, no flush, go to IDLE.
      - Taken and aligned: redirect=1, redirect_pc=target, go to FLUSH.
  - FLUSH: flush=1 for exactly FLUSH_CYCLES cycles. The first flush cycle coincides with the redirect pulse. br_ready=0. An internal down-counter loads FLUSH_CYCLES-1 and returns to IDLE at 0.
- Latency: accept at edge N → res_valid high during cycle N+2.
  - Throughput, not-taken: one branch per 2 cycles.
  - Throughput, taken: one branch per 1+FLUSH_CYCLES+1 cycles.
- Handshake: a transfer occurs only on br_valid && br_ready. Request fields are sampled only at transfer. br_valid held during busy states is ignored, not queued.
- Counters: increment on res_valid (err_funct3 cycles count as not taken) and saturate at all-ones.
  - cnt_clr has priority over a same-cycle increment.
- redirect_pc holds its last value between redirects.
- flush is never asserted without a preceding redirect.
- A reset mid-EVAL or mid-FLUSH aborts immediately: pulses and flush drop to 0 asynchronously, and no result is issued for the aborted branch.

Decomposition:
- Shared package: funct3 localparams (F3_BEQ…F3_BGEU), state encoding (ST_IDLE, ST_EVAL, ST_FLUSH).
- Sub-module branch_cond_unit: combinational eq/lt/ltu generation plus funct3 decode into cond and illegal. It is the unit verified standalone.
- The controller holds the FSM, registers, target adder, flush counter and statistics.

Test Plan:
- BEQ, rs1=rs2=0x0000_0005, pc=0x100, imm=0x20 → N+2: res_valid=1, res_taken=1, redirect=1, redirect_pc=0x120; flush high exactly 2 cycles; br_ready=1 at cycle N+4.
- BLT vs BLTU, rs1=0xFFFF_FFFF, rs2=1 → BLT: taken=1; BLTU: taken=0, no redirect, no flush, ready again at N+2.
- funct3=010 → err_funct3 pulse, res_taken=0, cnt_ntaken +1, no redirect.
- BNE taken, pc=0x100, imm=0x2 → err_misalign=1, no redirect/flush. Second case pc=0xFFFF_FFF0, imm=0x20 → redirect_pc=0x0000_0010 (wrap).
- Back-to-back: br_valid held high for 10 cycles with alternating taken/not-taken → only transfers while br_ready=1 are accepted; counters match the accepted count; cnt_clr asserted on an increment cycle leaves the counters at 0.
- rst_n pulled low during the FLUSH state → flush drops immediately, counters reset to 0, br_ready=1 on the first cycle after release.
